// File: rtl/router_pkg.sv
// Shared types and constants for the output-drain arbiter.
// State encoding, port count, header length-field bounds and watchdog default.
package router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } state_t;

    localparam int NUM_PORTS = 3;

    // Length field inside the header byte.
    localparam int LEN_HI = 7;
    localparam int LEN_LO = 2;
    localparam int LEN_W  = LEN_HI - LEN_LO + 1;
    // One extra bit so that length + parity never overflows.
    localparam int CNT_W  = LEN_W + 1;

    localparam int WD_LIMIT_DEFAULT = 30;

    localparam logic [NUM_PORTS-1:0] PORT_ONE       = NUM_PORTS'(1);
    localparam logic [NUM_PORTS-1:0] LAST_GRANT_RST = {1'b1, {(NUM_PORTS-1){1'b0}}};

endpackage

// File: rtl/router_rr_pick.sv
// Combinational round-robin selector: first requester strictly after the
// one-hot 'last' position, wrapping to the lowest index.
module router_rr_pick
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] request,
    input  logic [NUM_PORTS-1:0] last,
    output logic [NUM_PORTS-1:0] pick
);

    logic [NUM_PORTS-1:0] upper_mask;
    logic [NUM_PORTS-1:0] req_hi;
    logic [NUM_PORTS-1:0] hi_first;
    logic [NUM_PORTS-1:0] any_first;

    // Bits above the last owner; empty when last is the top port, which wraps.
    assign upper_mask = ~(last | (last - PORT_ONE));
    assign req_hi     = request & upper_mask;
    assign hi_first   = req_hi & (~req_hi + PORT_ONE);
    assign any_first  = request & (~request + PORT_ONE);
    assign pick       = (req_hi != '0) ? hi_first : any_first;

endmodule

// File: rtl/router_drain_arbiter.sv
// Drains three output FIFOs onto one shared byte bus, one packet at a time.
// Optional stall watchdog enabled by defining ROUTER_ARB_WATCHDOG_EN.
module router_drain_arbiter
    import router_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int WD_LIMIT = WD_LIMIT_DEFAULT
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [DATA_W-1:0]    dout_0,
    input  logic [DATA_W-1:0]    dout_1,
    input  logic [DATA_W-1:0]    dout_2,
    input  logic                 out_ready,
    output logic [NUM_PORTS-1:0] read_enb,
    output logic [NUM_PORTS-1:0] grant,
    output logic [DATA_W-1:0]    data_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] soft_reset
);

    if (WD_LIMIT < 2 || DATA_W < LEN_HI + 1) begin : g_bad_cfg
        $error("router_drain_arbiter: WD_LIMIT must be >= 2 and DATA_W must hold the length field");
    end

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] last_grant_q, last_grant_d;
    logic [NUM_PORTS-1:0] out_grant_q, out_grant_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 hdr_pend_q, hdr_pend_d;
    logic                 out_valid_q, out_valid_d;

    logic                 in_packet;
    logic                 fire;
    logic                 abort;
    logic [NUM_PORTS-1:0] pick;
    logic [CNT_W-1:0]     count_eff;
    logic [LEN_W-1:0]     len_field;
    logic [DATA_W-1:0]    out_mux;

    logic [DATA_W-1:0]    dout_arr  [NUM_PORTS];
    logic [DATA_W-1:0]    out_terms [NUM_PORTS];
    logic [LEN_W-1:0]     len_terms [NUM_PORTS];

    assign dout_arr[0] = dout_0;
    assign dout_arr[1] = dout_1;
    assign dout_arr[2] = dout_2;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign out_terms[gi] = out_grant_q[gi] ? dout_arr[gi] : '0;
        assign len_terms[gi] = grant_q[gi] ? dout_arr[gi][LEN_HI:LEN_LO] : '0;
    end

    always_comb begin
        out_mux   = '0;
        len_field = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            out_mux   = out_mux | out_terms[i];
            len_field = len_field | len_terms[i];
        end
    end

    router_rr_pick u_pick (
        .request (~fifo_empty),
        .last    (last_grant_q),
        .pick    (pick)
    );

    assign in_packet = (state_q == ST_HEAD) || (state_q == ST_BODY);
    assign fire      = in_packet && out_ready && ((grant_q & ~fifo_empty) != '0);
    assign read_enb  = fire ? grant_q : '0;

    // The header byte is on dout only in the first BODY cycle, so the count is
    // taken straight from it there and the body may read in that same cycle.
    assign count_eff = hdr_pend_q ? (CNT_W'(len_field) + CNT_W'(1)) : count_q;

`ifdef ROUTER_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    assign abort      = in_packet && !fire && (wd_q == WD_W'(WD_LIMIT - 1));
    assign soft_reset = abort ? grant_q : '0;

    always_comb begin
        wd_d = '0;
        if (in_packet && !fire && !abort) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign abort      = 1'b0;
    assign soft_reset = '0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        hdr_pend_d   = hdr_pend_q;
        out_valid_d  = fire;
        out_grant_d  = fire ? grant_q : out_grant_q;

        case (state_q)
            ST_IDLE: begin
                if (fifo_empty != '1) begin
                    grant_d = pick;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (fire) begin
                    state_d    = ST_BODY;
                    hdr_pend_d = 1'b1;
                end
            end
            ST_BODY: begin
                hdr_pend_d = 1'b0;
                count_d    = count_eff - CNT_W'(fire);
                if (fire && (count_eff == CNT_W'(1))) begin
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (abort) begin
            state_d      = ST_IDLE;
            grant_d      = '0;
            last_grant_d = grant_q;
            count_d      = '0;
            hdr_pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_GRANT_RST;
            out_grant_q  <= '0;
            count_q      <= '0;
            hdr_pend_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            out_grant_q  <= out_grant_d;
            count_q      <= count_d;
            hdr_pend_q   <= hdr_pend_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign grant     = grant_q;
    assign out_valid = out_valid_q;
    assign data_out  = out_valid_q ? out_mux : '0;
    // Busy also covers the cycle that presents the last byte.
    assign busy      = in_packet || out_valid_q;

endmodule

// File: tb/tb_router_drain_arbiter.sv
// Directed bench for router_drain_arbiter: FIFO models feed packets, a byte
// scoreboard checks the output stream; watchdog checks follow ROUTER_ARB_WATCHDOG_EN.
`timescale 1ns/1ps
module tb_router_drain_arbiter;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] fifo_empty = 3'b111;
    logic [7:0] dout_0 = 8'h00, dout_1 = 8'h00, dout_2 = 8'h00;
    logic       out_ready = 1'b1;
    logic [2:0] read_enb, grant, soft_reset;
    logic [7:0] data_out;
    logic       out_valid, busy;

    always #5 clock = ~clock;

    router_drain_arbiter dut (
        .clock      (clock),
        .resetn     (resetn),
        .fifo_empty (fifo_empty),
        .dout_0     (dout_0),
        .dout_1     (dout_1),
        .dout_2     (dout_2),
        .out_ready  (out_ready),
        .read_enb   (read_enb),
        .grant      (grant),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .soft_reset (soft_reset)
    );

    int n_cmp = 0, n_err = 0;
    logic [7:0] fq0[$], fq1[$], fq2[$], exp_q[$];
    logic [2:0] glog[$];

    logic [2:0] s_re, s_gr, s_sr, prev_gr, sr_val;
    logic [7:0] s_dout;
    logic       s_ov, s_busy;
    int cyc = 0, rd_cnt[3], ov_cnt, first_rd, first_ov, run, max_run;
    int last_rd_cyc, sr_cnt, sr_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic reset_stats();
        for (int i = 0; i < 3; i++) rd_cnt[i] = 0;
        ov_cnt = 0; first_rd = -1; first_ov = -1; run = 0; max_run = 0;
        last_rd_cyc = 0; sr_cnt = 0; sr_cyc = 0; sr_val = 3'b000;
        glog.delete();
    endtask

    task automatic update_empty();
        fifo_empty = {fq2.size() == 0, fq1.size() == 0, fq0.size() == 0};
    endtask

    task automatic push_byte(input int p, input logic [7:0] b);
        case (p)
            0:       fq0.push_back(b);
            1:       fq1.push_back(b);
            default: fq2.push_back(b);
        endcase
        exp_q.push_back(b);
    endtask

    task automatic load_pkt(input int p, input int len);
        logic [7:0] hdr, par, b;
        hdr = 8'(len << 2);
        par = hdr;
        push_byte(p, hdr);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            par = par ^ b;
            push_byte(p, b);
        end
        push_byte(p, par);
        update_empty();
    endtask

    // One clock: sample at the falling edge, apply FIFO pops just after the rising edge.
    task automatic cycle();
        logic [7:0] e;
        @(negedge clock);
        cyc++;
        s_re = read_enb; s_gr = grant; s_sr = soft_reset;
        s_dout = data_out; s_ov = out_valid; s_busy = busy;
        if (s_re != 3'b000) begin
            run++;
            last_rd_cyc = cyc;
            if (first_rd < 0) first_rd = cyc;
        end else begin
            run = 0;
        end
        if (run > max_run) max_run = run;
        for (int i = 0; i < 3; i++) if (s_re[i]) rd_cnt[i]++;
        if (s_ov) begin
            ov_cnt++;
            if (first_ov < 0) first_ov = cyc;
            chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("data_out", 32'(s_dout), 32'(e));
            end
        end else begin
            chk("data_out_idle", 32'(s_dout), 32'd0);
        end
        if (s_sr != 3'b000) begin
            sr_cnt++; sr_cyc = cyc; sr_val = s_sr;
        end
        if (s_gr != 3'b000 && prev_gr == 3'b000) glog.push_back(s_gr);
        prev_gr = s_gr;
        @(posedge clock);
        #1;
        if (s_re[0] && fq0.size() > 0) dout_0 = fq0.pop_front();
        if (s_re[1] && fq1.size() > 0) dout_1 = fq1.pop_front();
        if (s_re[2] && fq2.size() > 0) dout_2 = fq2.pop_front();
        update_empty();
    endtask

    task automatic run_idle(input string tag, input int maxc);
        int n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < maxc) begin
            cycle();
            n++;
            done = (s_busy == 1'b0) && (s_gr == 3'b000) && (fifo_empty == 3'b111);
        end
        chk({tag, "_idle_reached"}, 32'(done), 32'd1);
    endtask

    task automatic wait_reads(input string tag, input int p, input int n, input int maxc);
        int k;
        k = 0;
        while (rd_cnt[p] < n && k < maxc) begin
            cycle();
            k++;
        end
        chk({tag, "_reads_reached"}, 32'(rd_cnt[p] >= n), 32'd1);
    endtask

    function automatic logic [2:0] glog_at(input int k);
        return (glog.size() > k) ? glog[k] : 3'b000;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(s_gr), 32'd0);
        chk({tag, "_read_enb"}, 32'(s_re), 32'd0);
        chk({tag, "_out_valid"}, 32'(s_ov), 32'd0);
        chk({tag, "_data_out"}, 32'(s_dout), 32'd0);
        chk({tag, "_busy"}, 32'(s_busy), 32'd0);
        chk({tag, "_soft_reset"}, 32'(s_sr), 32'd0);
    endtask

    task automatic flush_all();
        fq0.delete(); fq1.delete(); fq2.delete(); exp_q.delete();
        update_empty();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        prev_gr = 3'b000;
        reset_stats();

        // Reset state
        resetn = 1'b0;
        cycle();
        cycle();
        check_all_zero("reset");
        resetn = 1'b1;

        // Simple packet, length 3, on port 0
        reset_stats();
        load_pkt(0, 3);
        run_idle("simple", 100);
        chk("simple_reads", 32'(rd_cnt[0]), 32'd5);
        chk("simple_read_run", 32'(max_run), 32'd5);
        chk("simple_out_valid", 32'(ov_cnt), 32'd5);
        chk("simple_lag", 32'(first_ov - first_rd), 32'd1);
        chk("simple_busy", 32'(s_busy), 32'd0);
        chk("simple_sb_empty", 32'(exp_q.size()), 32'd0);

        // Round robin after a fresh reset: 0,1,2 then 0 again
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        reset_stats();
        load_pkt(0, 1);
        load_pkt(1, 1);
        load_pkt(2, 1);
        load_pkt(0, 1);
        run_idle("rr", 200);
        chk("rr_grant_count", 32'(glog.size()), 32'd4);
        chk("rr_grant0", 32'(glog_at(0)), 32'd1);
        chk("rr_grant1", 32'(glog_at(1)), 32'd2);
        chk("rr_grant2", 32'(glog_at(2)), 32'd4);
        chk("rr_grant3", 32'(glog_at(3)), 32'd1);
        chk("rr_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure mid-payload on port 2
        begin
            int gap_rd, gap_ov;
            reset_stats();
            gap_rd = 0;
            gap_ov = 0;
            load_pkt(2, 4);
            wait_reads("bp", 2, 3, 50);
            out_ready = 1'b0;
            for (int g = 0; g < 4; g++) begin
                cycle();
                if (s_re != 3'b000) gap_rd++;
                if (g > 0 && s_ov) gap_ov++;
            end
            out_ready = 1'b1;
            run_idle("bp", 100);
            chk("bp_gap_reads", 32'(gap_rd), 32'd0);
            chk("bp_gap_valid", 32'(gap_ov), 32'd0);
            chk("bp_reads", 32'(rd_cnt[2]), 32'd6);
            chk("bp_out_valid", 32'(ov_cnt), 32'd6);
            chk("bp_grant", 32'(glog_at(0)), 32'd4);
            chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        end

        // Zero-length packet on port 1
        reset_stats();
        load_pkt(1, 0);
        run_idle("len0", 50);
        chk("len0_reads", 32'(rd_cnt[1]), 32'd2);
        chk("len0_other_reads", 32'(rd_cnt[0] + rd_cnt[2]), 32'd0);
        chk("len0_out_valid", 32'(ov_cnt), 32'd2);

        // Port 1 empties right after its header
        reset_stats();
        push_byte(1, 8'h08);
        update_empty();
        wait_reads("stall", 1, 1, 20);
        for (int i = 0; i < 40; i++) cycle();
        chk("stall_reads", 32'(rd_cnt[1]), 32'd1);
`ifdef ROUTER_ARB_WATCHDOG_EN
        chk("wd_pulse_count", 32'(sr_cnt), 32'd1);
        chk("wd_pulse_port", 32'(sr_val), 32'd2);
        chk("wd_pulse_delay", 32'(sr_cyc - last_rd_cyc), 32'd30);
        chk("wd_grant_after", 32'(s_gr), 32'd0);
        chk("wd_busy_after", 32'(s_busy), 32'd0);
`else
        chk("nowd_soft_reset", 32'(sr_cnt), 32'd0);
        chk("nowd_grant_held", 32'(s_gr), 32'd2);
        chk("nowd_busy_held", 32'(s_busy), 32'd1);
`endif

        // Reset in the middle of a body
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        flush_all();
        reset_stats();
        load_pkt(1, 3);
        wait_reads("midrst", 1, 3, 50);
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        flush_all();
        cycle();
        check_all_zero("midrst");
        reset_stats();
        load_pkt(0, 1);
        load_pkt(1, 1);
        run_idle("midrst", 100);
        chk("midrst_first_grant", 32'(glog_at(0)), 32'd1);
        chk("midrst_second_grant", 32'(glog_at(1)), 32'd2);
        chk("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_drain_arbiter.md
ROUTER_DRAIN_ARBITER -- requirements
Module: router_drain_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: byte width of FIFO read data and output bus.
REQ-002 Parameter WD_LIMIT, default 30: watchdog stall limit in cycles.
REQ-003 Port clock, input, 1: rising-edge clock.
REQ-004 Port resetn, input, 1: synchronous, active-low reset.
REQ-005 Port fifo_empty, input, 3: per-port empty flags for output FIFOs 0..2.
REQ-006 Port dout_0 / dout_1 / dout_2, input, DATA_W each: FIFO read data, valid the cycle after read_enb.
REQ-007 Port out_ready, input, 1: downstream can take a byte next cycle.
REQ-008 Port read_enb, output, 3: one-hot FIFO read strobes.
REQ-009 Port grant, output, 3: one-hot owner of the shared output, 0 when idle.
REQ-010 Port data_out, output, DATA_W: muxed byte from the granted port.
REQ-011 Port out_valid, output, 1: data_out valid this cycle.
REQ-012 Port busy, output, 1: a packet is in progress.
REQ-013 Port soft_reset, output, 3: one-cycle per-port abort pulse.

Function
REQ-014 States: IDLE, HEAD, BODY; encodings in the shared package.
REQ-015 IDLE: if any fifo_empty bit is low, grant the first non-empty port in round-robin order after last_grant, wrapping 2->0, and go to HEAD next cycle.
REQ-016 Read fire = grant[g] & !fifo_empty[g] & out_ready; read_enb[g] equals fire, combinationally, in HEAD and BODY only.
REQ-017 HEAD: on fire, go to BODY; no more reads in HEAD.
REQ-018 On the cycle after the header fire, load remaining count = dout_g[7:2] + 1 (payload plus parity, 7-bit unsigned).
REQ-019 Counting rules:
- BODY reads are allowed from the cycle the count is loaded.
- Each BODY fire decrements the count.
- The fire that takes the count to 0 is the last one; go to IDLE the next cycle and set last_grant = g.
REQ-020 out_valid is a register of fire, so it lags read_enb by exactly one cycle; data_out = dout of the registered grant while out_valid is high, else 0.
REQ-021 If the granted FIFO goes empty mid-packet, stall with no read and no change of state or grant.
REQ-022 A payload length of 0 gives a count of 1: header then parity only.
REQ-023 busy = 1 in HEAD and BODY, and also on the cycle that drains the final out_valid.
REQ-024 Other ports' empty flags are ignored while busy; there is no preemption.

Reset
REQ-025 When resetn is low at a clock edge:
- state = IDLE, grant = 0, read_enb = 0.
- out_valid = 0, data_out = 0, busy = 0, soft_reset = 0.
- count = 0, last_grant = 2, so that port 0 has first priority.
REQ-026 Reset mid-packet abandons the packet immediately, with no soft_reset pulse.

Configuration
REQ-027 Macro ROUTER_ARB_WATCHDOG_EN defined: a stall counter runs in HEAD and BODY.
- It clears on every fire and counts cycles without a fire.
- When it reaches WD_LIMIT, pulse soft_reset[g] for 1 cycle, go to IDLE, and set last_grant = g.
- Any partially loaded count is discarded.
REQ-028 Macro undefined: no stall counter, soft_reset is tied 0, and stalls last indefinitely.

Structure
REQ-029 Shared package router_pkg holds:
- the state typedef;
- the port-count constant 3;
- the length-field slice bounds [7:2];
- the WD_LIMIT default.
REQ-030 Submodule router_rr_pick: combinational round-robin selector (request[3], last[3] -> one-hot pick); the FSM, counter and watchdog stay in the top module.

Verification
REQ-031 Simple packet: FIFO0 holds header 0x0C (length 3), 3 payload bytes, parity; out_ready=1.
- read_enb[0] high for 5 consecutive cycles.
- out_valid high for 5 cycles, one cycle later.
- Returns to IDLE, busy falls.
REQ-032 Round-robin: all 3 FIFOs hold one length-1 packet; grant order is 0,1,2; a second packet queued on 0 is granted after 2.
REQ-033 Backpressure: out_ready low for 4 cycles mid-payload; no reads and no out_valid during the gap; byte order is preserved and the count is intact.
REQ-034 Length 0: header 0x00 gives exactly 2 reads (header plus parity) and then IDLE.
REQ-035 Watchdog (macro defined): FIFO1 goes empty after the header.
- soft_reset[1] pulses exactly 30 cycles after the last fire.
- Then grant = 0 and the FSM is in IDLE.
- Macro undefined: the FSM stays in BODY and soft_reset stays 0.
REQ-036 Reset mid-BODY: after resetn is low for 1 cycle, all outputs are 0 and the next grant goes to port 0 when it is non-empty.
